dispatcher_for_in_rep: RTL and testbench

Receive-side counterpart of the OUT_rep upload arbitration. Drains the IN_rep reply FIFO and routes each reply packet to the inst_cache download reg or the data_cache download reg, as decided by the head-flit cmd. The route is locked for the whole packet (head to tail), so flits of different packets never interleave at a consumer. Sits between IN_rep and the ic/dc download regs in communication_assist.

---
 rtl/comm_assist_pkg.sv | 29 ++
 rtl/rep_head_decode.sv | 20 ++
 rtl/dispatcher_for_in_rep.sv | 143 ++++++++++++++
 tb/tb_dispatcher_for_in_rep.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/comm_assist_pkg.sv
// Shared encodings for the communication_assist reply path: flit ctrl codes, reply
// cmds, dispatcher states and consumer select codes.
package comm_assist_pkg;

    localparam logic [1:0] CTRL_INV  = 2'b00;
    localparam logic [1:0] CTRL_HEAD = 2'b01;
    localparam logic [1:0] CTRL_BODY = 2'b10;
    localparam logic [1:0] CTRL_TAIL = 2'b11;

    localparam logic [4:0] nackrep_cmd  = 5'b10101;
    localparam logic [4:0] SCflurep_cmd = 5'b11100;
    localparam logic [4:0] instrep_cmd  = 5'b10000;

    typedef enum logic [2:0] {
        disp_idle      = 3'b001,
        ic_downloading = 3'b010,
        dc_downloading = 3'b100
    } disp_state_e;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_IC   = 2'b01;
    localparam logic [1:0] SEL_DC   = 2'b10;

    // The reply cmd lives in bits [9:5] of a head flit.
    function automatic logic [4:0] rep_cmd(input logic [15:0] flit);
        return flit[9:5];
    endfunction

endpackage

// File: rtl/rep_head_decode.sv
// Combinational head-flit classifier shared by the IN_rep dispatcher and the
// OUT_rep side: head detection, ic/dc route and single-flit packet detection.
module rep_head_decode
    import comm_assist_pkg::*;
(
    input  logic [15:0] flit,
    input  logic [1:0]  ctrl,
    output logic        is_head,
    output logic        to_ic,
    output logic        single_flit
);

    logic [4:0] cmd;

    assign cmd         = rep_cmd(flit);
    assign is_head     = (ctrl == CTRL_HEAD);
    assign to_ic       = (cmd == instrep_cmd);
    assign single_flit = is_head && ((cmd == nackrep_cmd) || (cmd == SCflurep_cmd));

endmodule

// File: rtl/dispatcher_for_in_rep.sv
// Drains IN_rep and routes each reply packet, locked head-to-tail, to the inst_cache
// or data_cache download reg. Optional DISPATCH_ERR_CNT_EN adds a saturating err_cnt.
module dispatcher_for_in_rep
    import comm_assist_pkg::*;
#(
    parameter int MAX_FLITS = 11,
    parameter int CNT_W     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        v_IN_rep,
    input  logic [15:0] IN_rep_flit,
    input  logic [1:0]  IN_rep_ctrl,
    input  logic        ic_download_rdy,
    input  logic        dc_download_rdy,
    output logic        ack_IN_rep,
    output logic        v_ic_download,
    output logic        v_dc_download,
    output logic [15:0] download_flit,
    output logic [1:0]  download_ctrl,
    output logic [1:0]  select,
    output logic        protocol_err,
    output logic [2:0]  state
`ifdef DISPATCH_ERR_CNT_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_FLITS);

    disp_state_e      cur_state, nxt_state;
    logic [CNT_W-1:0] flit_cnt, nxt_cnt, cnt_inc;
    logic             is_head, to_ic, single_flit;
    logic             tgt_rdy, lock_rdy;

    rep_head_decode u_decode (
        .flit        (IN_rep_flit),
        .ctrl        (IN_rep_ctrl),
        .is_head     (is_head),
        .to_ic       (to_ic),
        .single_flit (single_flit)
    );

    assign state         = cur_state;
    assign download_flit = rst ? 16'h0 : IN_rep_flit;
    assign download_ctrl = rst ? 2'b00 : IN_rep_ctrl;
    assign tgt_rdy       = to_ic ? ic_download_rdy : dc_download_rdy;
    assign lock_rdy      = (cur_state == ic_downloading) ? ic_download_rdy : dc_download_rdy;
    assign cnt_inc       = flit_cnt + CNT_W'(1);

    always_comb begin
        ack_IN_rep    = 1'b0;
        v_ic_download = 1'b0;
        v_dc_download = 1'b0;
        select        = SEL_NONE;
        protocol_err  = 1'b0;
        nxt_state     = cur_state;
        nxt_cnt       = flit_cnt;
        case (cur_state)
            disp_idle: begin
                if (v_IN_rep) begin
                    if (is_head) begin
                        if (tgt_rdy) begin
                            ack_IN_rep    = 1'b1;
                            v_ic_download = to_ic;
                            v_dc_download = !to_ic;
                            select        = to_ic ? SEL_IC : SEL_DC;
                            if (!single_flit) begin
                                nxt_state = to_ic ? ic_downloading : dc_downloading;
                                nxt_cnt   = CNT_W'(1);
                            end
                        end
                    end else begin
                        // Orphan body/tail is popped and flagged; ctrl 00 is popped silently.
                        ack_IN_rep   = 1'b1;
                        protocol_err = (IN_rep_ctrl != CTRL_INV);
                    end
                end
            end
            ic_downloading, dc_downloading: begin
                if (v_IN_rep) begin
                    if (is_head) begin
                        // Truncated packet: leave the new head in the FIFO for idle to decode.
                        protocol_err = 1'b1;
                        nxt_state    = disp_idle;
                        nxt_cnt      = '0;
                    end else if (IN_rep_ctrl == CTRL_INV) begin
                        ack_IN_rep = 1'b1;
                    end else if (lock_rdy) begin
                        ack_IN_rep    = 1'b1;
                        v_ic_download = (cur_state == ic_downloading);
                        v_dc_download = (cur_state == dc_downloading);
                        select        = (cur_state == ic_downloading) ? SEL_IC : SEL_DC;
                        if (IN_rep_ctrl == CTRL_TAIL) begin
                            nxt_state = disp_idle;
                            nxt_cnt   = '0;
                        end else if (cnt_inc >= CNT_MAX) begin
                            protocol_err = 1'b1;
                            nxt_state    = disp_idle;
                            nxt_cnt      = '0;
                        end else begin
                            nxt_cnt = cnt_inc;
                        end
                    end
                end
            end
            default: begin
                nxt_state = disp_idle;
                nxt_cnt   = '0;
            end
        endcase
        // Outputs read zero for as long as reset is held, independent of the inputs.
        if (rst) begin
            ack_IN_rep    = 1'b0;
            v_ic_download = 1'b0;
            v_dc_download = 1'b0;
            select        = SEL_NONE;
            protocol_err  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= disp_idle;
            flit_cnt  <= '0;
        end else begin
            cur_state <= nxt_state;
            flit_cnt  <= nxt_cnt;
        end
    end

`ifdef DISPATCH_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= 8'h00;
        end else if (protocol_err && (err_cnt != 8'hff)) begin
            err_cnt <= err_cnt + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_dispatcher_for_in_rep.sv
// Directed bench for dispatcher_for_in_rep: packet routing, backpressure, orphan and
// truncated packets, flit-count overflow and asynchronous reset.
module tb_dispatcher_for_in_rep;

    logic        clk = 1'b0;
    logic        rst;
    logic        v_IN_rep;
    logic [15:0] IN_rep_flit;
    logic [1:0]  IN_rep_ctrl;
    logic        ic_download_rdy;
    logic        dc_download_rdy;
    logic        ack_IN_rep;
    logic        v_ic_download;
    logic        v_dc_download;
    logic [15:0] download_flit;
    logic [1:0]  download_ctrl;
    logic [1:0]  select;
    logic        protocol_err;
    logic [2:0]  state;
`ifdef DISPATCH_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int exp_errs = 0;
    logic [15:0] exp_q[$];

    // expected output vector {ack, v_ic, v_dc, select[1:0], protocol_err}
    localparam logic [5:0] O_NONE = 6'b000000;
    localparam logic [5:0] O_IC   = 6'b110010;
    localparam logic [5:0] O_DC   = 6'b101100;
    localparam logic [5:0] O_DCE  = 6'b101101;
    localparam logic [5:0] O_ORPH = 6'b100001;
    localparam logic [5:0] O_DROP = 6'b100000;
    localparam logic [5:0] O_TRNC = 6'b000001;

    localparam logic [2:0] S_IDLE = 3'b001;
    localparam logic [2:0] S_IC   = 3'b010;
    localparam logic [2:0] S_DC   = 3'b100;

    localparam logic [1:0] HEAD = 2'b01;
    localparam logic [1:0] BODY = 2'b10;
    localparam logic [1:0] TAIL = 2'b11;
    localparam logic [1:0] INV  = 2'b00;

    // heads: cmd in [9:5]
    localparam logic [15:0] H_IC   = 16'h0201;  // instrep
    localparam logic [15:0] H_NACK = 16'h02A0;  // nackrep
    localparam logic [15:0] H_SCF  = 16'h0383;  // SCflurep
    localparam logic [15:0] H_DC   = 16'h0025;  // some other cmd -> dc

    dispatcher_for_in_rep dut (
        .clk             (clk),
        .rst             (rst),
        .v_IN_rep        (v_IN_rep),
        .IN_rep_flit     (IN_rep_flit),
        .IN_rep_ctrl     (IN_rep_ctrl),
        .ic_download_rdy (ic_download_rdy),
        .dc_download_rdy (dc_download_rdy),
        .ack_IN_rep      (ack_IN_rep),
        .v_ic_download   (v_ic_download),
        .v_dc_download   (v_dc_download),
        .download_flit   (download_flit),
        .download_ctrl   (download_ctrl),
        .select          (select),
        .protocol_err    (protocol_err),
        .state           (state)
`ifdef DISPATCH_ERR_CNT_EN
        ,
        .err_cnt         (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] outs();
        return {ack_IN_rep, v_ic_download, v_dc_download, select, protocol_err};
    endfunction

    // One cycle: present inputs, check combinational outputs, clock, check next state.
    task automatic cyc(input logic v, input logic [15:0] flit, input logic [1:0] ctrl,
                       input logic icr, input logic dcr,
                       input logic [5:0] exp_o, input logic [2:0] exp_s, input string tag);
        v_IN_rep        = v;
        IN_rep_flit     = flit;
        IN_rep_ctrl     = ctrl;
        ic_download_rdy = icr;
        dc_download_rdy = dcr;
        if (exp_o[4] || exp_o[3]) exp_q.push_back(flit);
        if (exp_o[0]) exp_errs++;
        #2;
        check({tag, ".outs"}, 32'(outs()), 32'(exp_o));
        if ((v_ic_download || v_dc_download) && exp_q.size() > 0) begin
            check({tag, ".flit"}, 32'({download_ctrl, download_flit}), 32'({ctrl, exp_q.pop_front()}));
        end
        @(posedge clk);
        #1;
        check({tag, ".state"}, 32'(state), 32'(exp_s));
    endtask

    initial begin
        rst = 1'b1;
        v_IN_rep = 1'b1;
        IN_rep_flit = H_IC;
        IN_rep_ctrl = HEAD;
        ic_download_rdy = 1'b1;
        dc_download_rdy = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset.outs", 32'(outs()), 32'(O_NONE));
        check("reset.state", 32'(state), 32'(S_IDLE));
`ifdef DISPATCH_ERR_CNT_EN
        check("reset.err_cnt", 32'(err_cnt), 32'd0);
`endif
        v_IN_rep = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ic packet: head, 3 body, tail
        cyc(1, H_IC,    HEAD, 1, 0, O_IC, S_IC,   "ic_head");
        for (int i = 0; i < 3; i++)
            cyc(1, 16'h1110 + 16'(i), BODY, 1, 0, O_IC, S_IC, "ic_body");
        cyc(1, 16'h1FFF, TAIL, 1, 0, O_IC, S_IDLE, "ic_tail");
        cyc(0, 16'h0, INV, 1, 1, O_NONE, S_IDLE, "idle_quiet");

        // single-flit packets stay in idle
        cyc(1, H_NACK, HEAD, 0, 1, O_DC, S_IDLE, "nack");
        cyc(1, H_SCF,  HEAD, 0, 1, O_DC, S_IDLE, "scflu");

        // head waits for its own target; ic_rdy is irrelevant for a dc head
        cyc(1, H_DC, HEAD, 1, 0, O_NONE, S_IDLE, "dc_head_wait");
        cyc(1, H_IC, HEAD, 0, 1, O_NONE, S_IDLE, "ic_head_wait");

        // dc packet with 3 cycles of backpressure mid-body
        cyc(1, H_DC,    HEAD, 0, 1, O_DC, S_DC, "dc_head");
        cyc(1, 16'h2001, BODY, 0, 1, O_DC, S_DC, "dc_body0");
        for (int i = 0; i < 3; i++)
            cyc(1, 16'h2002, BODY, 1, 0, O_NONE, S_DC, "dc_stall");
        cyc(1, 16'h2002, BODY, 0, 1, O_DC, S_DC, "dc_body1");
        cyc(1, 16'h2FFF, TAIL, 0, 1, O_DC, S_IDLE, "dc_tail");

        // orphans and invalid ctrl in idle
        cyc(1, 16'h3001, BODY, 1, 1, O_ORPH, S_IDLE, "orphan_body");
        cyc(1, 16'h3002, TAIL, 1, 1, O_ORPH, S_IDLE, "orphan_tail");
        cyc(1, 16'h3003, INV,  1, 1, O_DROP, S_IDLE, "drop_inv");

        // new head before tail truncates the ic packet; head then taken from idle
        cyc(1, H_IC,     HEAD, 1, 1, O_IC,   S_IC,   "trunc_head");
        cyc(1, 16'h4001, BODY, 1, 1, O_IC,   S_IC,   "trunc_body");
        cyc(1, H_DC,     HEAD, 1, 1, O_TRNC, S_IDLE, "trunc_new_head");
        cyc(1, H_DC,     HEAD, 1, 1, O_DC,   S_DC,   "trunc_redecode");
        cyc(1, 16'h4FFF, TAIL, 1, 1, O_DC,   S_IDLE, "trunc_tail");

        // overflow: head + 10 body; error on the 11th transfer
        cyc(1, H_DC, HEAD, 0, 1, O_DC, S_DC, "ovf_head");
        for (int i = 0; i < 9; i++)
            cyc(1, 16'h5000 + 16'(i), BODY, 0, 1, O_DC, S_DC, "ovf_body");
        cyc(1, 16'h50AA, BODY, 0, 1, O_DCE, S_IDLE, "ovf_11th");
        cyc(1, 16'h50BB, TAIL, 0, 1, O_ORPH, S_IDLE, "ovf_leftover");

        // max-length packet with tail as the 11th flit is legal
        cyc(1, H_DC, HEAD, 0, 1, O_DC, S_DC, "max_head");
        for (int i = 0; i < 9; i++)
            cyc(1, 16'h6000 + 16'(i), BODY, 0, 1, O_DC, S_DC, "max_body");
        cyc(1, 16'h6FFF, TAIL, 0, 1, O_DC, S_IDLE, "max_tail");

`ifdef DISPATCH_ERR_CNT_EN
        check("err_cnt", 32'(err_cnt), 32'(exp_errs));
`endif

        // asynchronous reset mid-packet
        cyc(1, H_IC, HEAD, 1, 1, O_IC, S_IC, "arst_head");
        v_IN_rep = 1'b1;
        IN_rep_flit = 16'h7001;
        IN_rep_ctrl = BODY;
        #1;
        check("arst_pre.outs", 32'(outs()), 32'(O_IC));
        rst = 1'b1;
        #1;
        check("arst.outs", 32'(outs()), 32'(O_NONE));
        check("arst.state", 32'(state), 32'(S_IDLE));
        check("arst.flit", 32'(download_flit), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_errs = 0;
        cyc(1, 16'h7002, BODY, 1, 1, O_ORPH, S_IDLE, "arst_orphan");
`ifdef DISPATCH_ERR_CNT_EN
        check("err_cnt_after_rst", 32'(err_cnt), 32'(exp_errs));
`endif

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
